// File: rtl/param_cam.sv
// ---------------------------------------------------------------------------
// param_cam
//   Parameterised content-addressable memory. It has DEPTH entries, and each
//   entry holds a WIDTH-bit word and a valid bit.
//   Operations are WRITE, INVALIDATE and SEARCH.
//   SEARCH returns the result one cycle later:
//     - found:      at least one valid entry matched the key
//     - match_addr: the lowest matching index
//     - multi:      two or more valid entries matched the key
//   The occupancy count and the full flag are registered.
// ---------------------------------------------------------------------------
module param_cam #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data,
    output logic             result_valid,
    output logic             found,
    output logic [AW-1:0]    match_addr,
    output logic             multi,
    output logic [AW:0]      count,
    output logic             full
);

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SEARCH = 2'b01,
        OP_WRITE  = 2'b10,
        OP_INVAL  = 2'b11
    } op_e;

    // DEPTH expressed in the count width. It always fits, because DEPTH <= 2**AW.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // -----------------------------------------------------------------------
    // Storage and registered outputs
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic             r_result_valid;
    logic             r_found;
    logic [AW-1:0]    r_match_addr;
    logic             r_multi;
    logic [AW:0]      r_count;
    logic             r_full;

    // -----------------------------------------------------------------------
    // Operation decode
    // -----------------------------------------------------------------------
    op_e              w_op;
    logic             w_addr_ok;
    logic             w_do_search;
    logic             w_do_write;
    logic             w_do_inval;
    logic             w_tgt_valid;

    assign w_op        = op_e'(op);
    // When DEPTH is not a power of two, some addr codes name no entry.
    // WRITE and INVALIDATE to those codes are dropped.
    assign w_addr_ok   = ({1'b0, addr} < DEPTH_W);
    assign w_do_search = ena && (w_op == OP_SEARCH);
    assign w_do_write  = ena && (w_op == OP_WRITE) && w_addr_ok;
    assign w_do_inval  = ena && (w_op == OP_INVAL) && w_addr_ok;
    assign w_tgt_valid = w_addr_ok ? r_valid[addr] : 1'b0;

    // -----------------------------------------------------------------------
    // Match vector
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0] w_hit;

    // Compare the key against every entry. Invalid entries can never hit.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch.
        // If a path skipped an assignment, synthesis would infer a latch.
        w_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit[i] = r_valid[i] && (r_mem[i] == data);
        end
    end

    // -----------------------------------------------------------------------
    // Priority encode and multi-hit detection
    // -----------------------------------------------------------------------
    logic             w_found;
    logic [AW-1:0]    w_match_addr;
    logic             w_multi;

    // Scan upward. The first hit fixes the address; any later hit sets multi.
    always_comb begin
        w_found      = 1'b0;
        w_match_addr = '0;
        w_multi      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_hit[i]) begin
                if (w_found) begin
                    w_multi = 1'b1;
                end else begin
                    w_match_addr = AW'(i);
                end
                w_found = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Occupancy bookkeeping
    // -----------------------------------------------------------------------
    logic [AW:0]      w_count_nxt;

    // Count changes only when an op actually flips the target's valid bit.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_write && !w_tgt_valid) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_do_inval && w_tgt_valid) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential logic
    // -----------------------------------------------------------------------

    // Data words: written on WRITE only, and never while reset is asserted.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset. The valid bits gate every use of
        // a word, so a reset here would only cost a mux per bit.
        if (rst_n && w_do_write) begin
            r_mem[addr] <= data;
        end
    end

    // Valid bits: set by WRITE, cleared by INVALIDATE, all cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments, so every flop samples
        // its inputs from before the edge, whatever order the blocks run in.
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_do_write) begin
            r_valid[addr] <= 1'b1;
        end else if (w_do_inval) begin
            r_valid[addr] <= 1'b0;
        end
    end

    // Search result: pulse valid for one cycle; hold the other fields until
    // the next result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result_valid <= 1'b0;
            r_found        <= 1'b0;
            r_match_addr   <= '0;
            r_multi        <= 1'b0;
        end else begin
            r_result_valid <= w_do_search;
            if (w_do_search) begin
                r_found      <= w_found;
                r_match_addr <= w_match_addr;
                r_multi      <= w_multi;
            end
        end
    end

    // Registered count and full flag, both taken from the next-count value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_W);
        end
    end

    assign result_valid = r_result_valid;
    assign found        = r_found;
    assign match_addr   = r_match_addr;
    assign multi        = r_multi;
    assign count        = r_count;
    assign full         = r_full;

endmodule

// File: tb/tb_param_cam.sv
// ---------------------------------------------------------------------------
// tb_param_cam
//   Scoreboard bench for param_cam (WIDTH=8, DEPTH=16).
//   Each issued SEARCH pushes its expected result into a queue. A monitor pops
//   the queue and compares on every result_valid pulse. On all other cycles
//   the monitor checks that found, match_addr and multi hold their last value.
// ---------------------------------------------------------------------------
module tb_param_cam;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [1:0] NOP    = 2'b00;
    localparam logic [1:0] SEARCH = 2'b01;
    localparam logic [1:0] WRITE  = 2'b10;
    localparam logic [1:0] INVAL  = 2'b11;

    typedef struct {
        logic          found;
        logic [AW-1:0] addr;
        logic          multi;
        logic [AW:0]   cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic [1:0]       op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             result_valid;
    logic             found;
    logic [AW-1:0]    match_addr;
    logic             multi;
    logic [AW:0]      count;
    logic             full;

    exp_t sb_q[$];
    exp_t hold_exp = '{found: 1'b0, addr: '0, multi: 1'b0, cnt: '0};
    int   n_cmp = 0;
    int   n_bad = 0;

    param_cam #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .op           (op),
        .addr         (addr),
        .data         (data),
        .result_valid (result_valid),
        .found        (found),
        .match_addr   (match_addr),
        .multi        (multi),
        .count        (count),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: result_valid=1 with nothing pending (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result{found,addr,multi,count}",
                      32'({found, match_addr, multi, count}),
                      32'({e.found, e.addr, e.multi, e.cnt}));
                hold_exp = e;
            end
        end else begin
            check("hold{result_valid,found,addr,multi}",
                  32'({result_valid, found, match_addr, multi}),
                  32'({1'b0, hold_exp.found, hold_exp.addr, hold_exp.multi}));
        end
    end

    // One op per edge. Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic e, input logic [1:0] o,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        ena  = e;
        op   = o;
        addr = a;
        data = d;
        @(posedge clk);
        #1;
        ena = 1'b0;
        op  = NOP;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        drive(1'b1, WRITE, a, d);
    endtask

    task automatic inval(input logic [AW-1:0] a);
        drive(1'b1, INVAL, a, '0);
    endtask

    task automatic srch(input logic [WIDTH-1:0] key, input logic f,
                        input logic [AW-1:0] a, input logic m, input logic [AW:0] c);
        exp_t e;
        e.found = f;
        e.addr  = a;
        e.multi = m;
        e.cnt   = c;
        sb_q.push_back(e);
        drive(1'b1, SEARCH, '0, key);
    endtask

    task automatic check_stat(input string name, input logic [AW:0] c, input logic f);
        check(name, 32'({count, full}), 32'({c, f}));
    endtask

    // Watchdog: end the run even if the stimulus were ever to stall.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        op    = NOP;
        addr  = '0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_stat("reset_count_full", 5'd0, 1'b0);
        rst_n = 1'b1;

        // No writes yet, so the search must miss. This exercises valid-bit gating.
        srch(8'h00, 1'b0, 4'd0, 1'b0, 5'd0);
        drive(1'b0, NOP, '0, '0);

        // Four writes, then four back-to-back searches.
        wr(4'd0,  8'h55);
        wr(4'd1,  8'hAA);
        wr(4'd2,  8'h77);
        wr(4'd15, 8'h33);
        check_stat("count_after_4_writes", 5'd4, 1'b0);
        srch(8'h55, 1'b1, 4'd0,  1'b0, 5'd4);
        srch(8'hAA, 1'b1, 4'd1,  1'b0, 5'd4);
        srch(8'h77, 1'b1, 4'd2,  1'b0, 5'd4);
        srch(8'h33, 1'b1, 4'd15, 1'b0, 5'd4);
        repeat (2) drive(1'b1, NOP, '0, '0);

        // Duplicate keys: the lowest index wins and multi is set.
        // After the invalidate, the stale word at entry 3 must not match.
        wr(4'd3, 8'h5A);
        wr(4'd9, 8'h5A);
        srch(8'h5A, 1'b1, 4'd3, 1'b1, 5'd6);
        inval(4'd3);
        srch(8'h5A, 1'b1, 4'd9, 1'b0, 5'd5);

        // Overwrite a valid entry: the count stays the same.
        wr(4'd1, 8'hCC);
        check_stat("count_after_overwrite", 5'd5, 1'b0);
        srch(8'hAA, 1'b0, 4'd0, 1'b0, 5'd5);
        srch(8'hCC, 1'b1, 4'd1, 1'b0, 5'd5);

        // With ena=0, the op is ignored.
        drive(1'b0, INVAL,  4'd0, '0);
        drive(1'b0, WRITE,  4'd4, 8'h11);
        drive(1'b0, SEARCH, 4'd0, 8'h55);
        srch(8'h55, 1'b1, 4'd0, 1'b0, 5'd5);
        srch(8'h11, 1'b0, 4'd0, 1'b0, 5'd5);
        check_stat("count_after_ena0", 5'd5, 1'b0);

        // Fill the remaining 11 entries.
        for (int i = 3; i < 15; i++) begin
            if (i != 9) wr(AW'(i), 8'(8'h10 + i));
        end
        check_stat("full_at_16", 5'd16, 1'b1);

        // A write while full overwrites normally.
        wr(4'd4, 8'hE4);
        check_stat("write_when_full", 5'd16, 1'b1);
        srch(8'hE4, 1'b1, 4'd4, 1'b0, 5'd16);
        srch(8'h14, 1'b0, 4'd0, 1'b0, 5'd16);
        srch(8'h1E, 1'b1, 4'd14, 1'b0, 5'd16);

        // Invalidating the same entry twice decrements the count only once.
        inval(4'd7);
        check_stat("single_invalidate", 5'd15, 1'b0);
        inval(4'd7);
        check_stat("double_invalidate", 5'd15, 1'b0);
        srch(8'h17, 1'b0, 4'd0, 1'b0, 5'd15);
        drive(1'b0, NOP, '0, '0);

        // Reset with a SEARCH in the same cycle: no result pulse.
        // The held outputs and the count clear.
        rst_n = 1'b0;
        drive(1'b1, SEARCH, '0, 8'h55);
        hold_exp = '{found: 1'b0, addr: '0, multi: 1'b0, cnt: '0};
        check_stat("count_after_reset", 5'd0, 1'b0);
        rst_n = 1'b1;

        // An op in the first cycle out of reset is accepted. The array is now empty.
        srch(8'h55, 1'b0, 4'd0, 1'b0, 5'd0);
        srch(8'hCC, 1'b0, 4'd0, 1'b0, 5'd0);
        repeat (3) drive(1'b0, NOP, '0, '0);

        check("pending_results_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
